// File: rtl/pio_pkg.sv
// Shared types and helpers for the PIO output shift register.
package pio_pkg;

   typedef enum logic {
      SHIFT_LEFT  = 1'b0,
      SHIFT_RIGHT = 1'b1
   } shift_dir_e;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } osr_state_e;

   // Bit counts encode a full word as 0.
   function automatic int unsigned dec_count(input int unsigned val, input int unsigned full);
      return (val == 0) ? full : val;
   endfunction

endpackage

// File: rtl/pio_out_shifter_if.sv
// Instruction, TX FIFO and config bundle between the PIO sequencer and the OSR.
interface pio_out_shifter_if
   import pio_pkg::*;
#(
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              out_req;
   logic [CNT_W-2:0]  out_count;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              pull_req;
   logic              pull_block;
   logic              pull_ifempty;
   logic [DATA_W-1:0] x_value;
   logic              mov_wr;
   logic [DATA_W-1:0] mov_wdata;
   logic [DATA_W-1:0] osr_rdata;
   logic              cfg_shiftdir;
   logic              cfg_autopull;
   logic [CNT_W-2:0]  cfg_pull_thresh;
   logic              stall;
   logic [CNT_W-1:0]  osr_count;
   osr_state_e        osr_state;

   modport master (
      output tx_data, tx_valid, out_req, out_count, pull_req, pull_block, pull_ifempty,
             x_value, mov_wr, mov_wdata, cfg_shiftdir, cfg_autopull, cfg_pull_thresh,
      input  tx_ready, out_data, out_valid, osr_rdata, stall, osr_count, osr_state
   );

   modport slave (
      input  tx_data, tx_valid, out_req, out_count, pull_req, pull_block, pull_ifempty,
             x_value, mov_wr, mov_wdata, cfg_shiftdir, cfg_autopull, cfg_pull_thresh,
      output tx_ready, out_data, out_valid, osr_rdata, stall, osr_count, osr_state
   );

endinterface

// File: rtl/pio_bit_extract.sv
// Combinational n-bit extract from an OSR word plus the zero-filled remainder.
module pio_bit_extract
   import pio_pkg::*;
#(
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic [DATA_W-1:0] i_word,
   input  logic [CNT_W-1:0]  i_n,
   input  shift_dir_e        i_dir,
   output logic [DATA_W-1:0] o_bits,
   output logic [DATA_W-1:0] o_rest
);

   logic [CNT_W-1:0] w_gap;

   assign w_gap = CNT_W'(DATA_W) - i_n;

   // i_n == DATA_W makes the remainder shift clear the whole word.
   always_comb begin
      if (i_dir == SHIFT_LEFT) begin
         o_bits = i_word >> w_gap;
         o_rest = i_word << i_n;
      end else begin
         o_bits = (i_word << w_gap) >> w_gap;
         o_rest = i_word >> i_n;
      end
   end

endmodule

// File: rtl/pio_out_shifter.sv
// PIO output shift register with autopull, PULL/MOV paths and stall backpressure.
// Define PIO_OSR_PULL_IFEMPTY_EN to honour the PULL IFEMPTY qualifier.
module pio_out_shifter
   import pio_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   pio_out_shifter_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

   logic [DATA_W-1:0] r_osr;
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   osr_state_e        r_state;

   logic [CNT_W-1:0]  w_thr;
   logic [CNT_W-1:0]  w_n;
   logic              w_empty;
   logic              w_ifempty;
   logic              w_mov;
   logic              w_pull;
   logic              w_out;
   logic [CNT_W:0]    w_sum;
   logic [CNT_W-1:0]  w_new_cnt;
   logic [DATA_W-1:0] w_bits;
   logic [DATA_W-1:0] w_rest;
   logic [DATA_W-1:0] w_osr_d;
   logic [CNT_W-1:0]  w_cnt_d;
   logic              w_fire;
   logic              w_stall;
   logic              w_pop;

`ifdef PIO_OSR_PULL_IFEMPTY_EN
   assign w_ifempty = bus.pull_ifempty;
`else
   logic unused_ifempty;
   assign unused_ifempty = bus.pull_ifempty;
   assign w_ifempty      = 1'b0;
`endif

   assign w_thr   = CNT_W'(dec_count(32'(bus.cfg_pull_thresh), DATA_W));
   assign w_n     = CNT_W'(dec_count(32'(bus.out_count), DATA_W));
   assign w_empty = (r_count >= w_thr);

   assign w_mov  = bus.mov_wr;
   assign w_pull = bus.pull_req & ~bus.mov_wr;
   assign w_out  = bus.out_req & ~bus.mov_wr & ~bus.pull_req;

   assign w_sum     = {1'b0, r_count} + {1'b0, w_n};
   assign w_new_cnt = (w_sum > (CNT_W + 1)'(DATA_W)) ? CNT_W'(DATA_W) : w_sum[CNT_W-1:0];

   pio_bit_extract #(
      .DATA_W (DATA_W)
   ) u_extract (
      .i_word (r_osr),
      .i_n    (w_n),
      .i_dir  (shift_dir_e'(bus.cfg_shiftdir)),
      .o_bits (w_bits),
      .o_rest (w_rest)
   );

   always_comb begin
      w_osr_d = r_osr;
      w_cnt_d = r_count;
      w_fire  = 1'b0;
      w_stall = 1'b0;
      w_pop   = 1'b0;
      if (w_mov) begin
         w_osr_d = bus.mov_wdata;
         w_cnt_d = '0;
      end else if (w_pull) begin
         if (!(w_ifempty && !w_empty)) begin
            if (bus.tx_valid) begin
               w_pop   = 1'b1;
               w_osr_d = bus.tx_data;
               w_cnt_d = '0;
            end else if (bus.pull_block) begin
               w_stall = 1'b1;
            end else begin
               w_osr_d = bus.x_value;
               w_cnt_d = '0;
            end
         end
      end else if (w_out) begin
         if (bus.cfg_autopull && w_empty) begin
            // Refill now; the OUT re-issues next cycle on the fresh word.
            w_stall = 1'b1;
            if (bus.tx_valid) begin
               w_pop   = 1'b1;
               w_osr_d = bus.tx_data;
               w_cnt_d = '0;
            end
         end else begin
            w_fire  = 1'b1;
            w_osr_d = w_rest;
            w_cnt_d = w_new_cnt;
            if (bus.cfg_autopull && (w_new_cnt >= w_thr) && bus.tx_valid) begin
               w_pop   = 1'b1;
               w_osr_d = bus.tx_data;
               w_cnt_d = '0;
            end
         end
      end else if (bus.cfg_autopull && w_empty && bus.tx_valid) begin
         w_pop   = 1'b1;
         w_osr_d = bus.tx_data;
         w_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_osr       <= '0;
         r_count     <= CNT_W'(DATA_W);
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_state     <= RUN;
      end else begin
         r_osr       <= w_osr_d;
         r_count     <= w_cnt_d;
         r_out_valid <= w_fire;
         if (w_fire) begin
            r_out_data <= w_bits;
         end
         case (r_state)
            RUN:     if (w_stall)  r_state <= STALL;
            STALL:   if (!w_stall) r_state <= RUN;
            default: r_state <= RUN;
         endcase
      end
   end

   // Handshake outputs are held low while reset is asserted.
   assign bus.tx_ready  = w_pop & ~rst;
   assign bus.stall     = w_stall & ~rst;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign bus.osr_rdata = r_osr;
   assign bus.osr_count = r_count;
   assign bus.osr_state = r_state;

endmodule

// File: tb/tb_pio_out_shifter.sv
// Directed bench for pio_out_shifter; OUT results are checked through a scoreboard queue.
module tb_pio_out_shifter;
   import pio_pkg::*;

   localparam int unsigned DW = 32;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] osr;
      logic [5:0]  cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;
   exp_t sb[$];

   pio_out_shifter_if #(.DATA_W(DW)) bus ();

   pio_out_shifter #(.DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
   endtask

   task automatic clr();
      bus.mov_wr       = 1'b0;
      bus.pull_req     = 1'b0;
      bus.out_req      = 1'b0;
      bus.pull_block   = 1'b0;
      bus.pull_ifempty = 1'b0;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic mov(input logic [31:0] d);
      bus.mov_wr    = 1'b1;
      bus.mov_wdata = d;
      cyc();
      clr();
   endtask

   task automatic out_go(input logic [4:0] n, input logic [31:0] d, input logic [31:0] o,
                         input logic [5:0] c);
      exp_t e;
      e.data = d;
      e.osr  = o;
      e.cnt  = c;
      sb.push_back(e);
      bus.out_req   = 1'b1;
      bus.out_count = n;
   endtask

   // Monitor: every out_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (bus.out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected out_valid: actual out_data 0x%08h required no pulse",
                     bus.out_data);
         end else begin
            e = sb.pop_front();
            chk("out_data", bus.out_data, e.data);
            chk("osr after OUT", bus.osr_rdata, e.osr);
            chk("count after OUT", 32'(bus.osr_count), 32'(e.cnt));
         end
      end
   end

   initial begin
      clr();
      bus.tx_data         = '0;
      bus.tx_valid        = 1'b0;
      bus.out_count       = '0;
      bus.x_value         = '0;
      bus.mov_wdata       = '0;
      bus.cfg_shiftdir    = 1'b0;
      bus.cfg_autopull    = 1'b0;
      bus.cfg_pull_thresh = '0;
      #1 rst = 1'b1;
      #1;
      chk("reset osr", bus.osr_rdata, 32'h0);
      chk("reset count", 32'(bus.osr_count), 32'd32);
      chk("reset out_data", bus.out_data, 32'h0);
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset tx_ready", 32'(bus.tx_ready), 32'd0);
      chk("reset stall", 32'(bus.stall), 32'd0);
      chk("reset state", 32'(bus.osr_state), 32'(RUN));
      @(negedge clk);
      rst = 1'b0;

      // MOV then left OUT 8
      mov(32'hDEADBEEF);
      out_go(5'd8, 32'h000000DE, 32'hADBEEF00, 6'd8);
      cyc();
      clr();

      // Right OUT 16 hits threshold 16 and refills in the same cycle
      bus.cfg_shiftdir    = 1'b1;
      bus.cfg_pull_thresh = 5'd16;
      bus.cfg_autopull    = 1'b1;
      mov(32'hAAAA5555);
      bus.tx_valid = 1'b1;
      bus.tx_data  = 32'h12345678;
      out_go(5'd16, 32'h00005555, 32'h12345678, 6'd0);
      #1;
      chk("post-OUT autopull tx_ready", 32'(bus.tx_ready), 32'd1);
      chk("post-OUT autopull stall", 32'(bus.stall), 32'd0);
      cyc();
      clr();
      bus.tx_valid = 1'b0;

      // Drain with a full right OUT, then OUT on empty OSR with FIFO empty
      out_go(5'd0, 32'h12345678, 32'h0, 6'd32);
      cyc();
      clr();
      bus.cfg_shiftdir = 1'b0;
      bus.out_req      = 1'b1;
      bus.out_count    = 5'd4;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("autopull stall, FIFO empty", 32'(bus.stall), 32'd1);
         chk("no pop while FIFO empty", 32'(bus.tx_ready), 32'd0);
         cyc();
      end
      chk("state while stalled", 32'(bus.osr_state), 32'(STALL));
      chk("count held while stalled", 32'(bus.osr_count), 32'd32);
      bus.tx_valid = 1'b1;
      bus.tx_data  = 32'hF0000000;
      #1;
      chk("refill cycle stall", 32'(bus.stall), 32'd1);
      chk("refill cycle tx_ready", 32'(bus.tx_ready), 32'd1);
      cyc();
      bus.tx_valid = 1'b0;
      chk("refilled osr", bus.osr_rdata, 32'hF0000000);
      chk("refilled count", 32'(bus.osr_count), 32'd0);
      out_go(5'd4, 32'h0000000F, 32'h0, 6'd4);
      #1;
      chk("re-issued OUT stall", 32'(bus.stall), 32'd0);
      cyc();
      clr();
      chk("state back to RUN", 32'(bus.osr_state), 32'(RUN));

      // PULL noblock with FIFO empty loads X
      bus.cfg_autopull = 1'b0;
      bus.pull_req     = 1'b1;
      bus.x_value      = 32'h00000055;
      #1;
      chk("noblock PULL stall", 32'(bus.stall), 32'd0);
      cyc();
      clr();
      chk("noblock PULL osr", bus.osr_rdata, 32'h00000055);
      chk("noblock PULL count", 32'(bus.osr_count), 32'd0);

      // Blocking PULL stalls until data arrives
      bus.pull_req   = 1'b1;
      bus.pull_block = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("blocking PULL stall", 32'(bus.stall), 32'd1);
         cyc();
      end
      chk("osr unchanged during PULL stall", bus.osr_rdata, 32'h00000055);
      bus.tx_valid = 1'b1;
      bus.tx_data  = 32'h0BADCAFE;
      #1;
      chk("blocking PULL released stall", 32'(bus.stall), 32'd0);
      chk("blocking PULL tx_ready", 32'(bus.tx_ready), 32'd1);
      cyc();
      clr();
      bus.tx_valid = 1'b0;
      chk("blocking PULL osr", bus.osr_rdata, 32'h0BADCAFE);

      // MOV beats a simultaneous OUT; then PULL IFEMPTY at count 4, thr 32
      bus.cfg_pull_thresh = 5'd0;
      bus.mov_wr          = 1'b1;
      bus.mov_wdata       = 32'h11112222;
      bus.out_req         = 1'b1;
      bus.out_count       = 5'd4;
      cyc();
      clr();
      chk("MOV priority osr", bus.osr_rdata, 32'h11112222);
      chk("MOV priority count", 32'(bus.osr_count), 32'd0);
      out_go(5'd4, 32'h00000001, 32'h11122220, 6'd4);
      cyc();
      clr();
      bus.pull_req     = 1'b1;
      bus.pull_block   = 1'b1;
      bus.pull_ifempty = 1'b1;
      bus.tx_valid     = 1'b1;
      bus.tx_data      = 32'h99999999;
      #1;
`ifdef PIO_OSR_PULL_IFEMPTY_EN
      chk("IFEMPTY PULL tx_ready", 32'(bus.tx_ready), 32'd0);
      cyc();
      clr();
      chk("IFEMPTY PULL osr", bus.osr_rdata, 32'h11122220);
      chk("IFEMPTY PULL count", 32'(bus.osr_count), 32'd4);
`else
      chk("IFEMPTY PULL tx_ready", 32'(bus.tx_ready), 32'd1);
      cyc();
      clr();
      chk("IFEMPTY PULL osr", bus.osr_rdata, 32'h99999999);
      chk("IFEMPTY PULL count", 32'(bus.osr_count), 32'd0);
`endif
      bus.tx_valid = 1'b0;

      // Full-word left OUT, then stall and reset mid-stall
      mov(32'hCAFEF00D);
      out_go(5'd0, 32'hCAFEF00D, 32'h0, 6'd32);
      cyc();
      clr();
      bus.cfg_autopull = 1'b1;
      bus.out_req      = 1'b1;
      bus.out_count    = 5'd4;
      #1;
      chk("stall before reset", 32'(bus.stall), 32'd1);
      cyc();
      chk("state before reset", 32'(bus.osr_state), 32'(STALL));
      #2 rst = 1'b1;
      #1;
      chk("mid-stall reset state", 32'(bus.osr_state), 32'(RUN));
      chk("mid-stall reset count", 32'(bus.osr_count), 32'd32);
      chk("mid-stall reset osr", bus.osr_rdata, 32'h0);
      chk("mid-stall reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid-stall reset out_data", bus.out_data, 32'h0);
      chk("mid-stall reset stall", 32'(bus.stall), 32'd0);
      clr();
      bus.cfg_autopull = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cyc();

      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pio_out_shifter.md
Name: pio_out_shifter

Overview:
- Second-generation PIO output shift register (OSR), parametrised in data width, with explicit stall signalling and valid/ready TX-FIFO handshake.
- Sits between the state machine's TX FIFO and the OUT/MOV/PULL execution paths.
- Implements the PIO autopull semantics for OUT and non-OUT cycles, plus blocking and non-blocking PULL.
- Backpressures the instruction sequencer through `stall` instead of silently dropping data.

Parameters:
- DATA_W, 32, OSR and FIFO word width; power of two, 8..32.
- CNT_W, $clog2(DATA_W)+1, width of the shift counter; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- tx_data  in  DATA_W  TX FIFO head word
- tx_valid  in  1  FIFO not empty
- tx_ready  out  1  pop strobe; word consumed this cycle
- out_req  in  1  OUT instruction issued
- out_count  in  CNT_W-1  bits to shift; 0 means DATA_W
- out_data  out  DATA_W  shifted-out bits, right-justified
- out_valid  out  1  out_data updated, one-cycle pulse
- pull_req  in  1  PULL instruction issued
- pull_block  in  1  1 = blocking PULL, 0 = noblock
- pull_ifempty  in  1  PULL IFEMPTY qualifier
- x_value  in  DATA_W  scratch X; loaded into OSR on noblock-empty PULL
- mov_wr  in  1  MOV OSR, src
- mov_wdata  in  DATA_W  MOV source data
- osr_rdata  out  DATA_W  current OSR contents, combinational from register
- cfg_shiftdir  in  1  0 = left, 1 = right
- cfg_autopull  in  1  autopull enable
- cfg_pull_thresh  in  CNT_W-1  threshold; 0 means DATA_W
- stall  out  1  instruction must re-issue next cycle
- osr_count  out  CNT_W  bits consumed, 0..DATA_W

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. Reset values:
  - osr = 0, osr_count = DATA_W (empty)
  - out_data = 0, out_valid = 0, tx_ready = 0, stall = 0
- Instructions are mutually exclusive.
  - If more than one is asserted, priority is mov_wr > pull_req > out_req.
  - Non-winning requests are ignored; they are not stalled.
- Derived values:
  - thr = cfg_pull_thresh, or DATA_W if 0.
  - n = out_count, or DATA_W if 0.
  - empty = (osr_count >= thr).
- MOV: osr <= mov_wdata, osr_count <= 0, no FIFO pop.
- PULL:
  - If pull_ifempty and not empty: no-op.
  - Else if tx_valid: osr <= tx_data, count <= 0, tx_ready = 1.
  - Else if pull_block: stall = 1, OSR unchanged.
  - Else (noblock, FIFO empty): osr <= x_value, count <= 0.
- OUT, when autopull is set and empty:
  - If tx_valid: refill (osr <= tx_data, count <= 0, tx_ready = 1), stall = 1. The OUT re-executes next cycle on fresh data.
  - Else: stall = 1, no change.
- OUT, otherwise:
  - Left shift: out_data = osr[DATA_W-1 -: n], right-justified.
  - Right shift: out_data = osr[n-1:0].
  - Remaining bits of out_data are 0.
  - osr shifts by n with zero fill.
  - osr_count <= min(count + n, DATA_W).
  - out_valid pulses next cycle.
- Post-OUT autopull:
  - Applies if autopull is set, the new count is >= thr, and tx_valid.
  - Refills in the same cycle: osr = tx_data, count = 0, tx_ready = 1. The refill overrides the shifted value.
  - No stall.
- Idle-cycle autopull: with no instruction, autopull set, empty, and tx_valid, refill with tx_ready = 1.
- Timing:
  - stall and tx_ready are combinational from the current state and requests.
  - out_data, out_valid, osr and osr_count are registered, giving 1-cycle latency.
- FSM:
  - RUN to STALL when a stall is asserted.
  - STALL to RUN on the first cycle with no stall.
  - The state is exported only for debug/assertions; the datapath is identical in both states.
- Full shift: n = DATA_W shifts out the whole word and leaves osr = 0.
- No wrap: count saturates at DATA_W.
- Reset mid-stall returns to RUN with the empty OSR.

Optional Feature:
- Macro PIO_OSR_PULL_IFEMPTY_EN.
- Defined: pull_ifempty is honoured as above.
- Undefined: pull_ifempty is ignored and tied off internally, so every PULL behaves as a plain PULL.

Decomposition:
- Shared package pio_pkg holds:
  - typedef shift_dir_e (SHIFT_LEFT, SHIFT_RIGHT)
  - the FSM state enum osr_state_e (RUN, STALL)
  - the count-decode helper: 0 maps to DATA_W.
- One sub-module, pio_bit_extract: combinational n-bit extract/shift for both directions, shared by the OUT path.

Test Plan:
- DATA_W=32, MOV 0xDEADBEEF, shiftdir=0, OUT 8 → out_data=0x000000DE, osr=0xADBEEF00, osr_count=8.
- shiftdir=1, thr=16, autopull, FIFO holds 0x12345678, OSR 0xAAAA5555 at count 0 → OUT 16 gives out_data=0x5555; same cycle osr=0x12345678, count=0, tx_ready pulse.
- OSR empty, autopull, FIFO empty, OUT 4 → stall held 3 cycles. When FIFO is loaded with 0xF0000000: refill with stall, then OUT gives out_data=0xF.
- FIFO empty: PULL noblock with X=0x55 → osr=0x55, count=0. PULL block → stall until tx_valid, then osr=tx_data.
- PULL IFEMPTY at count 4, thr 32, macro on → no pop, OSR unchanged. With the macro off → pops.
- OUT 0 (=32) on osr=0xCAFEF00D, left shift → out_data=0xCAFEF00D, osr=0, count=32. Assert rst in the next cycle → count=32, out_valid=0.
